// File: rtl/uart_wb_bridge_pkg.sv
// Shared types and byte codes for the UART-to-Wishbone bridge.
package uart_wb_bridge_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GET_ADDR = 3'd1,
    GET_DATA = 3'd2,
    BUS      = 3'd3,
    SEND     = 3'd4
  } state_t;

  localparam logic [7:0] CMD_WR  = 8'h57;
  localparam logic [7:0] CMD_RD  = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h06;
  localparam logic [7:0] RSP_NAK = 8'h15;

endpackage

// File: rtl/uart_wb_bridge_if.sv
// Wishbone classic bus between the bridge (master) and the SoC fabric (slave).
interface uart_wb_bridge_if;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i;
  logic        wb_err_i;

  modport master (
    output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    input  wb_dat_i, wb_ack_i, wb_err_i
  );

  modport slave (
    input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_dat_o, wb_sel_o,
    output wb_dat_i, wb_ack_i, wb_err_i
  );
endinterface

// File: rtl/uart_byte_phy.sv
// 8N1 byte deserialiser/serialiser, DIV clocks per bit.
// tx_busy drops in the final stop-bit clock so a queued byte follows with no idle gap.
module uart_byte_phy #(
  parameter int DIV = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       tx,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  output logic       rx_ferr,
  input  logic       tx_start,
  input  logic [7:0] tx_data,
  output logic       tx_busy
);
  localparam int CW = $clog2(DIV + 1);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);
  localparam logic [CW-1:0] HALF = CW'(DIV / 2 - 1);

  logic          rx_s1, rx_s2, rx_prev, rx_act;
  logic [CW-1:0] rx_cnt;
  logic [3:0]    rx_bit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_act   <= 1'b0;
      rx_cnt   <= '0;
      rx_bit   <= '0;
      rx_data  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_s1    <= rx;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (!rx_act) begin
        if (rx_prev && !rx_s2) begin
          rx_act <= 1'b1;
          rx_cnt <= '0;
          rx_bit <= '0;
        end
      end else if (rx_cnt == ((rx_bit == 4'd0) ? HALF : LAST)) begin
        rx_cnt <= '0;
        rx_bit <= rx_bit + 4'd1;
        // bit 0 is the mid-start recheck, bit 9 the stop sample
        if (rx_bit == 4'd0) begin
          if (rx_s2) rx_act <= 1'b0;
        end else if (rx_bit == 4'd9) begin
          rx_act   <= 1'b0;
          rx_valid <= rx_s2;
          rx_ferr  <= !rx_s2;
        end else begin
          rx_data <= {rx_s2, rx_data[7:1]};
        end
      end else begin
        rx_cnt <= rx_cnt + 1'b1;
      end
    end
  end

  logic          tx_act;
  logic [CW-1:0] tx_cnt;
  logic [3:0]    tx_bit;
  logic [8:0]    tx_sh;

  assign tx_busy = tx_act && !(tx_bit == 4'd9 && tx_cnt == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx     <= 1'b1;
      tx_act <= 1'b0;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= '1;
    end else if (tx_start && !tx_busy) begin
      tx     <= 1'b0;
      tx_act <= 1'b1;
      tx_cnt <= '0;
      tx_bit <= '0;
      tx_sh  <= {1'b1, tx_data};
    end else if (tx_act) begin
      if (tx_cnt == LAST) begin
        tx_cnt <= '0;
        if (tx_bit == 4'd9) begin
          tx_act <= 1'b0;
          tx     <= 1'b1;
        end else begin
          tx     <= tx_sh[0];
          tx_sh  <= {1'b1, tx_sh[8:1]};
          tx_bit <= tx_bit + 4'd1;
        end
      end else begin
        tx_cnt <= tx_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_wb_bridge.sv
// Serial-command Wishbone master: parses 0x57/0x52 packets, runs one classic cycle, replies.
// Optional UART_WB_BRIDGE_TIMEOUT_EN aborts a cycle with NAK after TIMEOUT_CYCLES clocks.
module uart_wb_bridge
  import uart_wb_bridge_pkg::*;
#(
  parameter int CLK_FREQ       = 200_000_000,
  parameter int BAUD           = 115200,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rx,
  output logic                    uart_tx,
  uart_wb_bridge_if.master        wb,
  output logic                    busy,
  output logic [7:0]              debug
);
  localparam int DIV = CLK_FREQ / BAUD;
  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TCW-1:0] TLAST = TCW'(TIMEOUT_CYCLES - 1);
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic       rx_valid, rx_ferr, tx_start, tx_busy;
  logic [7:0] rx_data, tx_data;

  uart_byte_phy #(.DIV(DIV)) u_phy (
    .clk(clk), .rst(rst), .rx(uart_rx), .tx(uart_tx),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ferr(rx_ferr),
    .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy)
  );

  state_t         state, state_n;
  logic [2:0]     cnt, cnt_n;
  logic [31:0]    adr, adr_n, dat, dat_n, rdata, rdata_n;
  logic           is_wr, is_wr_n, nak, nak_n, ferr_st, ferr_n, tmo_st, tmo_n;
  logic [TCW-1:0] tcnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      adr     <= '0;
      dat     <= '0;
      rdata   <= '0;
      is_wr   <= 1'b0;
      nak     <= 1'b0;
      ferr_st <= 1'b0;
      tmo_st  <= 1'b0;
      tcnt    <= '0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      adr     <= adr_n;
      dat     <= dat_n;
      rdata   <= rdata_n;
      is_wr   <= is_wr_n;
      nak     <= nak_n;
      ferr_st <= ferr_n;
      tmo_st  <= tmo_n;
      tcnt    <= (state == BUS) ? tcnt + 1'b1 : '0;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    adr_n    = adr;
    dat_n    = dat;
    rdata_n  = rdata;
    is_wr_n  = is_wr;
    nak_n    = nak;
    ferr_n   = ferr_st | rx_ferr;
    tmo_n    = tmo_st;
    tx_start = 1'b0;
    tx_data  = RSP_ACK;
    case (state)
      IDLE: if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
        is_wr_n = (rx_data == CMD_WR);
        cnt_n   = '0;
        state_n = GET_ADDR;
      end
      GET_ADDR: if (rx_ferr) begin
        state_n = IDLE;
      end else if (rx_valid) begin
        adr_n = {adr[23:0], rx_data};
        cnt_n = cnt + 3'd1;
        if (cnt == 3'd3) begin
          cnt_n   = '0;
          state_n = is_wr ? GET_DATA : BUS;
        end
      end
      GET_DATA: if (rx_ferr) begin
        state_n = IDLE;
      end else if (rx_valid) begin
        dat_n = {dat[23:0], rx_data};
        cnt_n = cnt + 3'd1;
        if (cnt == 3'd3) begin
          cnt_n   = '0;
          state_n = BUS;
        end
      end
      BUS: begin
        cnt_n = '0;
        if (wb.wb_err_i) begin
          nak_n   = 1'b1;
          state_n = SEND;
        end else if (wb.wb_ack_i) begin
          nak_n   = 1'b0;
          rdata_n = wb.wb_dat_i;
          state_n = SEND;
        end else if (TMO_EN && tcnt == TLAST) begin
          nak_n   = 1'b1;
          tmo_n   = 1'b1;
          state_n = SEND;
        end
      end
      SEND: if (!tx_busy) begin
        // byte 0 is the status; read data follows MSB first by shifting rdata
        tx_start = 1'b1;
        tx_data  = (cnt == 3'd0) ? (nak ? RSP_NAK : RSP_ACK) : rdata[31:24];
        if (cnt != 3'd0) rdata_n = {rdata[23:0], 8'h00};
        cnt_n = cnt + 3'd1;
        if (cnt == ((nak || is_wr) ? 3'd0 : 3'd4)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign wb.wb_cyc_o = (state == BUS);
  assign wb.wb_stb_o = (state == BUS);
  assign wb.wb_we_o  = is_wr;
  assign wb.wb_adr_o = adr;
  assign wb.wb_dat_o = dat;
  assign wb.wb_sel_o = 4'hF;

  assign busy  = (state != IDLE) || tx_busy;
  assign debug = {state, ferr_st, tmo_st & TMO_EN, 3'b000};

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Randomized self-checking bench for uart_wb_bridge (DIV=16) against a packet-level model.
module tb_uart_wb_bridge;
  typedef logic [7:0] bq_t[$];

  logic       clk = 1'b0, rst = 1'b1, uart_rx = 1'b1;
  wire        uart_tx, busy;
  wire  [7:0] debug;
  uart_wb_bridge_if bus();

  uart_wb_bridge #(.CLK_FREQ(1_600_000), .BAUD(100_000), .TIMEOUT_CYCLES(64)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .uart_tx(uart_tx),
    .wb(bus), .busy(busy), .debug(debug)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  // slave behaviour: 0 = ack, 1 = err+ack together, 2 = never respond
  int          slv_mode = 0, slv_delay = 0, stab_bad = 0, hi_len = 0;
  logic [31:0] slv_rdata = 32'h0;
  logic [31:0] log_adr[$], log_dat[$];
  logic        log_we[$];
  logic [3:0]  log_sel[$];
  logic [7:0]  tx_q[$];
  int          tx_t[$];
  int          stop_bad = 0;

  bit          exp_txn;
  logic [31:0] exp_adr, exp_dat;
  logic        exp_we;
  logic [7:0]  exp_rsp[$];

  initial begin : slave
    bit in_cyc;
    int wcnt;
    in_cyc = 0; wcnt = 0;
    bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = 32'h0;
    forever begin
      @(negedge clk);
      bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_dat_i = slv_rdata;
      if (rst) in_cyc = 0;
      else if (bus.wb_cyc_o && bus.wb_stb_o) begin
        if (!in_cyc) begin
          in_cyc = 1; wcnt = 0; hi_len = 0;
          log_adr.push_back(bus.wb_adr_o); log_dat.push_back(bus.wb_dat_o);
          log_we.push_back(bus.wb_we_o);   log_sel.push_back(bus.wb_sel_o);
        end else if (bus.wb_adr_o !== log_adr[$] || bus.wb_dat_o !== log_dat[$] ||
                     bus.wb_we_o !== log_we[$]) stab_bad++;
        hi_len++;
        if (slv_mode != 2 && wcnt == slv_delay) begin
          bus.wb_ack_i = 1'b1;
          bus.wb_err_i = (slv_mode == 1);
        end
        wcnt++;
      end else in_cyc = 0;
    end
  end

  initial begin : tx_monitor
    logic [7:0] b;
    int t0;
    forever begin
      @(negedge clk);
      if (uart_tx === 1'b0) begin
        t0 = cycle;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (16) @(negedge clk);
          b[i] = uart_tx;
        end
        repeat (16) @(negedge clk);
        if (uart_tx !== 1'b1) stop_bad++;
        tx_q.push_back(b); tx_t.push_back(t0);
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    logic [9:0] f;
    f = {~bad_stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) uart_rx = f[i];
      repeat (15) @(negedge clk);
    end
    @(negedge clk) uart_rx = 1'b1;
  endtask

  task automatic run_pkt(input bq_t p);
    foreach (p[i]) send_byte(p[i], 1'b0);
  endtask

  task automatic clear_logs();
    log_adr.delete(); log_dat.delete(); log_we.delete(); log_sel.delete();
    tx_q.delete(); tx_t.delete(); stab_bad = 0; stop_bad = 0;
  endtask

  task automatic wait_rsp(input int n, output bit ok);
    int k;
    k = 0;
    while (tx_q.size() < n && k < 4000) begin @(negedge clk); k++; end
    ok = (tx_q.size() >= n);
    repeat (400) @(negedge clk);
  endtask

  function automatic bq_t mk_wr(input logic [31:0] a, input logic [31:0] d);
    bq_t p;
    p = {8'h57, a[31:24], a[23:16], a[15:8], a[7:0], d[31:24], d[23:16], d[15:8], d[7:0]};
    return p;
  endfunction

  function automatic bq_t mk_rd(input logic [31:0] a);
    bq_t p;
    p = {8'h52, a[31:24], a[23:16], a[15:8], a[7:0]};
    return p;
  endfunction

  // Packet-level reference: first command byte with enough trailing bytes yields one cycle.
  function automatic void model(input bq_t p, input int mode, input logic [31:0] rd);
    exp_txn = 0; exp_rsp.delete();
    for (int i = 0; i < p.size(); i++) begin
      if (!exp_txn && (p[i] == 8'h57 || p[i] == 8'h52)) begin
        exp_we = (p[i] == 8'h57);
        if (i + (exp_we ? 8 : 4) < p.size()) begin
          exp_txn = 1;
          exp_adr = {p[i+1], p[i+2], p[i+3], p[i+4]};
          exp_dat = exp_we ? {p[i+5], p[i+6], p[i+7], p[i+8]} : 32'h0;
        end
      end
    end
    if (exp_txn) begin
      if (mode == 0) begin
        exp_rsp.push_back(8'h06);
        if (!exp_we) for (int s = 3; s >= 0; s--) exp_rsp.push_back(8'((rd >> (8 * s)) & 32'hFF));
      end else if (mode == 1) exp_rsp.push_back(8'h15);
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
      else exp_rsp.push_back(8'h15);
`endif
    end
  endfunction

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_chk++; if (uart_tx !== 1'b1 || bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0) begin
      n_fail++; $display("FAIL reset_lines tx=%b cyc=%b stb=%b, required 1 0 0", uart_tx, bus.wb_cyc_o, bus.wb_stb_o); end
    n_chk++; if (bus.wb_we_o !== 1'b0 || bus.wb_adr_o !== 32'h0 || bus.wb_dat_o !== 32'h0) begin
      n_fail++; $display("FAIL reset_bus we=%b adr=%h dat=%h, required zeros", bus.wb_we_o, bus.wb_adr_o, bus.wb_dat_o); end
    n_chk++; if (busy !== 1'b0 || debug !== 8'h00) begin
      n_fail++; $display("FAIL reset_status busy=%b debug=%h, required 0 00", busy, debug); end
    rst = 1'b0;
    repeat (20) @(negedge clk);
    n_chk++; if (uart_tx !== 1'b1 || busy !== 1'b0 || debug !== 8'h00) begin
      n_fail++; $display("FAIL post_reset_idle tx=%b busy=%b debug=%h", uart_tx, busy, debug); end
  endtask

  task automatic test_write();
    bq_t p; logic [31:0] a, d; bit ok;
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 32'h00001004 : $urandom;
      d = (k == 0) ? 32'hDEADBEEF : $urandom;
      slv_mode = 0; slv_delay = (k == 0) ? 3 : $urandom_range(0, 6);
      p = mk_wr(a, d); model(p, 0, 32'h0);
      clear_logs(); run_pkt(p); wait_rsp(exp_rsp.size(), ok);
      n_chk++; if (log_adr.size() != 1) begin
        n_fail++; $display("FAIL wr_cycles k=%0d got %0d, required 1", k, log_adr.size()); end
      else begin
        n_chk++; if (log_adr[0] !== exp_adr || log_dat[0] !== exp_dat || log_we[0] !== 1'b1 || log_sel[0] !== 4'hF) begin
          n_fail++; $display("FAIL wr_bus k=%0d adr=%h dat=%h we=%b sel=%h, required %h %h 1 f",
                             k, log_adr[0], log_dat[0], log_we[0], log_sel[0], exp_adr, exp_dat); end
      end
      n_chk++; if (!ok || tx_q.size() != exp_rsp.size() || tx_q[0] !== exp_rsp[0]) begin
        n_fail++; $display("FAIL wr_rsp k=%0d got %0d bytes first=%h, required 1 byte %h", k, tx_q.size(),
                           (tx_q.size() > 0) ? tx_q[0] : 8'hxx, exp_rsp[0]); end
      n_chk++; if (stab_bad != 0 || stop_bad != 0) begin
        n_fail++; $display("FAIL wr_stable k=%0d bus_changes=%0d bad_stops=%0d, required 0 0", k, stab_bad, stop_bad); end
    end
  endtask

  task automatic test_read();
    bq_t p; logic [31:0] a; bit ok;
    for (int k = 0; k < 3; k++) begin
      a = (k == 0) ? 32'h00000008 : $urandom;
      slv_rdata = (k == 0) ? 32'h12345678 : $urandom;
      slv_mode = 0; slv_delay = $urandom_range(0, 5);
      p = mk_rd(a); model(p, 0, slv_rdata);
      clear_logs(); run_pkt(p); wait_rsp(exp_rsp.size(), ok);
      n_chk++; if (log_adr.size() != 1 || log_adr[0] !== exp_adr || log_we[0] !== 1'b0) begin
        n_fail++; $display("FAIL rd_bus k=%0d cycles=%0d adr=%h we=%b, required 1 %h 0", k, log_adr.size(),
                           (log_adr.size() > 0) ? log_adr[0] : 32'hx, (log_we.size() > 0) ? log_we[0] : 1'bx, exp_adr); end
      n_chk++; if (!ok || tx_q.size() != exp_rsp.size()) begin
        n_fail++; $display("FAIL rd_rsp_count k=%0d got %0d, required %0d", k, tx_q.size(), exp_rsp.size()); end
      else begin
        for (int i = 0; i < exp_rsp.size(); i++) begin
          n_chk++; if (tx_q[i] !== exp_rsp[i]) begin
            n_fail++; $display("FAIL rd_rsp_byte k=%0d i=%0d got %h, required %h", k, i, tx_q[i], exp_rsp[i]); end
        end
        for (int i = 0; i + 1 < tx_t.size(); i++) begin
          n_chk++; if (tx_t[i+1] - tx_t[i] != 160) begin
            n_fail++; $display("FAIL rd_gap k=%0d i=%0d spacing %0d clocks, required 160", k, i, tx_t[i+1] - tx_t[i]); end
        end
      end
    end
  endtask

  task automatic test_noise_err();
    bq_t p; bit ok; logic [7:0] b;
    p = {8'h00, 8'h41};
    for (int k = 0; k < 2; k++) begin
      b = 8'($urandom_range(0, 255));
      if (b == 8'h57 || b == 8'h52) b = 8'h33;
      p.push_back(b);
    end
    model(p, 0, 32'h0);
    clear_logs(); run_pkt(p); wait_rsp(0, ok);
    n_chk++; if (log_adr.size() != 0 || tx_q.size() != 0 || exp_txn) begin
      n_fail++; $display("FAIL noise_ignored cycles=%0d tx_bytes=%0d, required 0 0", log_adr.size(), tx_q.size()); end
    n_chk++; if (busy !== 1'b0 || debug[7:5] !== 3'd0) begin
      n_fail++; $display("FAIL noise_idle busy=%b state=%0d, required 0 0", busy, debug[7:5]); end
    slv_mode = 1; slv_delay = $urandom_range(0, 4);
    p = mk_wr($urandom, $urandom); model(p, 1, 32'h0);
    clear_logs(); run_pkt(p); wait_rsp(exp_rsp.size(), ok);
    n_chk++; if (log_adr.size() != 1 || log_we[0] !== 1'b1) begin
      n_fail++; $display("FAIL err_cycle cycles=%0d, required 1 write", log_adr.size()); end
    n_chk++; if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h15) begin
      n_fail++; $display("FAIL err_rsp got %0d bytes first=%h, required 1 byte 15", tx_q.size(),
                         (tx_q.size() > 0) ? tx_q[0] : 8'hxx); end
  endtask

  task automatic test_framing();
    bq_t p; bit ok;
    slv_mode = 0; clear_logs();
    send_byte(8'h52, 1'b0); send_byte(8'h00, 1'b0); send_byte(8'h00, 1'b1);
    repeat (40) @(negedge clk);
    n_chk++; if (debug[4] !== 1'b1 || debug[7:5] !== 3'd0) begin
      n_fail++; $display("FAIL ferr_flag debug=%h, required bit4=1 state=0", debug); end
    slv_rdata = $urandom;
    p = mk_rd($urandom); model(p, 0, slv_rdata);
    clear_logs(); run_pkt(p); wait_rsp(exp_rsp.size(), ok);
    n_chk++; if (log_adr.size() != 1 || log_adr[0] !== exp_adr) begin
      n_fail++; $display("FAIL ferr_recover_bus cycles=%0d adr=%h, required 1 %h", log_adr.size(),
                         (log_adr.size() > 0) ? log_adr[0] : 32'hx, exp_adr); end
    n_chk++; if (!ok || tx_q != exp_rsp) begin
      n_fail++; $display("FAIL ferr_recover_rsp got %0d bytes, required %0d", tx_q.size(), exp_rsp.size()); end
    n_chk++; if (debug[4] !== 1'b1) begin
      n_fail++; $display("FAIL ferr_sticky debug=%h, required bit4 still 1", debug); end
  endtask

  task automatic test_reset_mid_bus();
    bq_t p; bit ok; int k;
    slv_mode = 2; clear_logs();
    run_pkt(mk_wr($urandom, $urandom));
    k = 0;
    while (bus.wb_cyc_o !== 1'b1 && k < 200) begin @(negedge clk); k++; end
    n_chk++; if (bus.wb_cyc_o !== 1'b1) begin
      n_fail++; $display("FAIL rstbus_cycle_start cyc=%b after %0d clocks, required 1", bus.wb_cyc_o, k); end
    #2 rst = 1'b1;
    #1;
    n_chk++; if (bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 || uart_tx !== 1'b1 || debug !== 8'h00) begin
      n_fail++; $display("FAIL rstbus_abort cyc=%b stb=%b tx=%b debug=%h, required 0 0 1 00",
                         bus.wb_cyc_o, bus.wb_stb_o, uart_tx, debug); end
    repeat (3) @(negedge clk);
    rst = 1'b0; slv_mode = 0; slv_rdata = $urandom;
    repeat (5) @(negedge clk);
    p = mk_rd($urandom); model(p, 0, slv_rdata);
    clear_logs(); run_pkt(p); wait_rsp(exp_rsp.size(), ok);
    n_chk++; if (!ok || log_adr.size() != 1 || tx_q != exp_rsp) begin
      n_fail++; $display("FAIL rstbus_recover cycles=%0d tx_bytes=%0d, required 1 %0d",
                         log_adr.size(), tx_q.size(), exp_rsp.size()); end
  endtask

`ifdef UART_WB_BRIDGE_TIMEOUT_EN
  task automatic test_timeout();
    bq_t p; bit ok;
    slv_mode = 2;
    p = mk_wr($urandom, $urandom); model(p, 2, 32'h0);
    clear_logs(); run_pkt(p); wait_rsp(exp_rsp.size(), ok);
    n_chk++; if (log_adr.size() != 1 || hi_len != 64) begin
      n_fail++; $display("FAIL tmo_len cycles=%0d high_clocks=%0d, required 1 64", log_adr.size(), hi_len); end
    n_chk++; if (!ok || tx_q.size() != 1 || tx_q[0] !== 8'h15) begin
      n_fail++; $display("FAIL tmo_rsp got %0d bytes, required 1 byte 15", tx_q.size()); end
    n_chk++; if (debug[3] !== 1'b1) begin
      n_fail++; $display("FAIL tmo_sticky debug=%h, required bit3=1", debug); end
    slv_mode = 0;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_noise_err();
    test_framing();
    test_reset_mid_bus();
`ifdef UART_WB_BRIDGE_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
